// File: rtl/video_types.sv
// Shared video-subsystem types: LCD mode encoding, STAT enable layout and
// the default dot/line timing of the 160x144 panel.
package video_types;

    parameter int LCD_DOTS_PER_LINE = 456;
    parameter int LCD_VISIBLE_LINES = 144;
    parameter int LCD_TOTAL_LINES   = 154;
    parameter int LCD_OAM_DOTS      = 80;
    parameter int LCD_XFER_DOTS     = 172;

    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } LcdMode;

    typedef struct packed {
        logic lyc;
        logic mode2;
        logic mode1;
        logic mode0;
    } StatEnable;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_OAM,
        ST_XFER,
        ST_HBLANK,
        ST_VBLANK
    } lcd_state_t;

    // OFF reports as HBlank so the register decoder sees mode 0 while disabled.
    function automatic LcdMode mode_of(lcd_state_t s);
        LcdMode m;
        case (s)
            ST_OAM:    m = OAM;
            ST_XFER:   m = XFER;
            ST_VBLANK: m = VBLANK;
            default:   m = HBLANK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lcd_timing_if.sv
// Control inputs and timing/status outputs of the LCD timing generator.
interface lcd_timing_if;
    import video_types::*;

    logic      dot_en;
    logic      lcd_on;
    logic [7:0] lyc;
    StatEnable stat_ie;

    logic [7:0] ly;
    LcdMode    mode;
    logic      lyc_match;
    logic      drawline;
    logic      frame_done;
    logic      vblank_irq;
    logic      stat_irq;

    modport master (
        output dot_en, lcd_on, lyc, stat_ie,
        input  ly, mode, lyc_match, drawline, frame_done, vblank_irq, stat_irq
    );

    modport slave (
        input  dot_en, lcd_on, lyc, stat_ie,
        output ly, mode, lyc_match, drawline, frame_done, vblank_irq, stat_irq
    );
endinterface

// File: rtl/lcd_timing.sv
// Dot/line counter and LCD mode FSM; emits drawline, frame/VBlank and STAT
// interrupt pulses and exposes LY/mode to the register decoder.
module lcd_timing
    import video_types::*;
#(
    parameter int DOTS_PER_LINE = video_types::LCD_DOTS_PER_LINE,
    parameter int VISIBLE_LINES = video_types::LCD_VISIBLE_LINES,
    parameter int TOTAL_LINES   = video_types::LCD_TOTAL_LINES,
    parameter int OAM_DOTS      = video_types::LCD_OAM_DOTS,
    parameter int XFER_DOTS     = video_types::LCD_XFER_DOTS
) (
    input  logic         clk,
    input  logic         reset,
    lcd_timing_if.slave  bus
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LINE_LAST = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] VIS_END   = 8'(VISIBLE_LINES);

    lcd_state_t state_q, state_d;
    logic [8:0] dot_q, dot_d;
    logic [7:0] line_q, line_d;
    LcdMode     mode_q, mode_d;
    logic       drawline_q, drawline_d;
    logic       frame_done_q, frame_done_d;
    logic       stat_line_q, stat_line_d;
    logic       stat_irq_q, stat_irq_d;

    function automatic lcd_state_t state_at(logic [8:0] d, logic [7:0] l);
        lcd_state_t s;
        if (l >= VIS_END)       s = ST_VBLANK;
        else if (d < OAM_END)   s = ST_OAM;
        else if (d < XFER_END)  s = ST_XFER;
        else                    s = ST_HBLANK;
        return s;
    endfunction

    always_comb begin
        state_d      = state_q;
        dot_d        = dot_q;
        line_d       = line_q;
        drawline_d   = 1'b0;
        frame_done_d = 1'b0;

        if (!bus.lcd_on) begin
            state_d = ST_OFF;
            dot_d   = '0;
            line_d  = '0;
        end else if (state_q == ST_OFF) begin
            state_d = ST_OAM;
            dot_d   = '0;
            line_d  = '0;
        end else if (bus.dot_en) begin
            if (dot_q == DOT_LAST) begin
                dot_d  = '0;
                line_d = (line_q == LINE_LAST) ? 8'd0 : line_q + 8'd1;
            end else begin
                dot_d = dot_q + 9'd1;
            end
            state_d      = state_at(dot_d, line_d);
            drawline_d   = (state_q == ST_OAM) && (state_d == ST_XFER);
            frame_done_d = (state_q != ST_VBLANK) && (state_d == ST_VBLANK);
        end

        mode_d = mode_of(state_d);

        // STAT line is evaluated on the post-edge position so its pulse lands
        // on the same edge as the counter change; it is held low while OFF.
        stat_line_d = (state_d != ST_OFF) &&
                      ((bus.stat_ie.lyc   && (line_d == bus.lyc)) ||
                       (bus.stat_ie.mode2 && (mode_d == OAM))     ||
                       (bus.stat_ie.mode1 && (mode_d == VBLANK))  ||
                       (bus.stat_ie.mode0 && (mode_d == HBLANK)));
        stat_irq_d  = stat_line_d && !stat_line_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_OFF;
            dot_q        <= '0;
            line_q       <= '0;
            mode_q       <= HBLANK;
            drawline_q   <= 1'b0;
            frame_done_q <= 1'b0;
            stat_line_q  <= 1'b0;
            stat_irq_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dot_q        <= dot_d;
            line_q       <= line_d;
            mode_q       <= mode_d;
            drawline_q   <= drawline_d;
            frame_done_q <= frame_done_d;
            stat_line_q  <= stat_line_d;
            stat_irq_q   <= stat_irq_d;
        end
    end

    assign bus.ly         = line_q;
    assign bus.mode       = mode_q;
    assign bus.lyc_match  = (line_q == bus.lyc);
    assign bus.drawline   = drawline_q;
    assign bus.frame_done = frame_done_q;
    assign bus.vblank_irq = frame_done_q;
    assign bus.stat_irq   = stat_irq_q;

endmodule

// File: tb/tb_lcd_timing.sv
// Scoreboard bench for lcd_timing: a position-based reference model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_lcd_timing;
    import video_types::*;

    localparam int D     = 40;
    localparam int VIS   = 12;
    localparam int TOT   = 16;
    localparam int OAMD  = 8;
    localparam int XFERD = 14;
    localparam int FRAME = D * TOT;

    typedef struct packed {
        logic [7:0] ly;
        logic [1:0] mode;
        logic       lyc_match;
        logic       drawline;
        logic       frame_done;
        logic       vblank_irq;
        logic       stat_irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_timing_if tif ();
    lcd_timing_if dif ();

    lcd_timing #(
        .DOTS_PER_LINE(D), .VISIBLE_LINES(VIS), .TOTAL_LINES(TOT),
        .OAM_DOTS(OAMD), .XFER_DOTS(XFERD)
    ) dut (
        .clk(clk), .reset(rst), .bus(tif)
    );

    lcd_timing dut_dflt (
        .clk(clk), .reset(rst), .bus(dif)
    );

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    bit m_on   = 1'b0;
    int m_pos  = 0;
    bit m_stat = 1'b0;
    int n_sb   = 0;

    function automatic int mode_at(int p);
        int l = p / D;
        int d = p % D;
        if (l >= VIS) return 1;
        if (d < OAMD) return 2;
        if (d < OAMD + XFERD) return 3;
        return 0;
    endfunction

    task automatic push_exp(input bit dl, input bit fd, input logic [7:0] lyc_v,
                            input logic [3:0] ie_v);
        exp_t e;
        int   ly_i = m_on ? m_pos / D : 0;
        int   md   = m_on ? mode_at(m_pos) : 0;
        bit   sl;
        sl = m_on && ((ie_v[3] && (ly_i == int'(lyc_v))) || (ie_v[2] && md == 2) ||
                      (ie_v[1] && md == 1) || (ie_v[0] && md == 0));
        e.ly         = 8'(ly_i);
        e.mode       = 2'(md);
        e.lyc_match  = (ly_i == int'(lyc_v));
        e.drawline   = dl;
        e.frame_done = fd;
        e.vblank_irq = fd;
        e.stat_irq   = sl && !m_stat;
        m_stat       = sl;
        exp_q.push_back(e);
    endtask

    // Called just after a falling edge: drives inputs for the next rising edge.
    task automatic step(input bit on_v, input bit en_v, input logic [7:0] lyc_v,
                        input logic [3:0] ie_v);
        bit dl = 1'b0;
        bit fd = 1'b0;
        tif.lcd_on  = on_v;
        tif.dot_en  = en_v;
        tif.lyc     = lyc_v;
        tif.stat_ie = ie_v;
        if (!on_v) begin
            m_on  = 1'b0;
            m_pos = 0;
        end else if (!m_on) begin
            m_on  = 1'b1;
            m_pos = 0;
        end else if (en_v) begin
            m_pos = (m_pos + 1) % FRAME;
            dl = (m_pos % D == OAMD) && (m_pos / D < VIS);
            fd = (m_pos == VIS * D);
        end
        push_exp(dl, fd, lyc_v, ie_v);
    endtask

    task automatic reset_cycle();
        rst    = 1'b1;
        m_on   = 1'b0;
        m_pos  = 0;
        m_stat = 1'b0;
        push_exp(1'b0, 1'b0, tif.lyc, tif.stat_ie);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_sb++;
                total++;
                if ({tif.ly, tif.mode, tif.lyc_match, tif.drawline, tif.frame_done,
                     tif.vblank_irq, tif.stat_irq} !== e) begin
                    bad++;
                    $display("FAIL sb n=%0d got ly=%0d mode=%0d lm=%b dl=%b fd=%b vi=%b si=%b want ly=%0d mode=%0d lm=%b dl=%b fd=%b vi=%b si=%b",
                             n_sb, tif.ly, tif.mode, tif.lyc_match, tif.drawline,
                             tif.frame_done, tif.vblank_irq, tif.stat_irq,
                             e.ly, e.mode, e.lyc_match, e.drawline, e.frame_done,
                             e.vblank_irq, e.stat_irq);
                end
            end
        end
    end

    initial begin : stim
        int first_dl;
        bit found;
        logic [7:0] lyc_r;
        logic [3:0] ie_r;

        tif.lcd_on = 1'b0; tif.dot_en = 1'b0; tif.lyc = 8'd0; tif.stat_ie = 4'b0000;
        dif.lcd_on = 1'b0; dif.dot_en = 1'b0; dif.lyc = 8'd0; dif.stat_ie = 4'b0000;

        // Default-parameter instance: first drawline and first line wrap.
        repeat (2) @(negedge clk);
        total++;
        if (dif.ly !== 8'd0 || dif.mode !== HBLANK || dif.drawline !== 1'b0 || dif.stat_irq !== 1'b0) begin
            bad++;
            $display("FAIL dflt_reset got ly=%0d mode=%0d dl=%b want 0 0 0", dif.ly, dif.mode, dif.drawline);
        end
        rst = 1'b0;
        @(negedge clk);
        dif.lcd_on = 1'b1;
        dif.dot_en = 1'b1;
        @(posedge clk); #1;
        total++;
        if (dif.mode !== OAM || dif.ly !== 8'd0) begin
            bad++;
            $display("FAIL dflt_oam_entry got mode=%0d ly=%0d want 2 0", dif.mode, dif.ly);
        end
        first_dl = 0;
        for (int k = 1; k <= 456; k++) begin
            @(posedge clk); #1;
            if (dif.drawline && first_dl == 0) first_dl = k;
            if (k == 455) begin
                total++;
                if (dif.ly !== 8'd0) begin
                    bad++;
                    $display("FAIL dflt_ly_455 got %0d want 0", dif.ly);
                end
            end
        end
        total++;
        if (dif.ly !== 8'd1) begin
            bad++;
            $display("FAIL dflt_ly_456 got %0d want 1", dif.ly);
        end
        total++;
        if (first_dl != 80) begin
            bad++;
            $display("FAIL dflt_first_drawline got %0d want 80", first_dl);
        end
        dif.lcd_on = 1'b0;

        // Main scoreboard run on the reduced-geometry instance.
        @(negedge clk); reset_cycle();
        @(negedge clk); reset_cycle();
        @(negedge clk); rst = 1'b0;
        step(1'b1, 1'b1, 8'd5, 4'b1000);
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            @(negedge clk); step(1'b1, 1'b1, 8'd5, 4'b1000);
        end
        for (int i = 0; i < FRAME + 60; i++) begin
            @(negedge clk); step(1'b1, 1'b1, 8'd5, 4'b0001);
        end
        for (int i = 0; i < 2 * FRAME + 40; i++) begin
            @(negedge clk); step(1'b1, 1'(i % 2 == 0), 8'd3, 4'b0100);
        end

        // Display off mid-line, then re-enable.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk); step(1'b1, 1'b1, 8'd3, 4'b0110);
            if (m_on && m_pos == 5 * D + 20) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reach_line5 got timeout want pos=%0d", 5 * D + 20);
        end
        repeat (3) begin
            @(negedge clk); step(1'b0, 1'b1, 8'd3, 4'b0110);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); step(1'b1, 1'b1, 8'd3, 4'b0110);
        end

        // Randomised traffic.
        lyc_r = 8'd0;
        ie_r  = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                lyc_r = 8'($urandom_range(0, TOT - 1));
                ie_r  = 4'($urandom);
            end
            @(negedge clk);
            step(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 9) < 7), lyc_r, ie_r);
        end

        // Asynchronous reset in the middle of pixel transfer on line 10.
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk); step(1'b1, 1'b1, 8'd10, 4'b1111);
            if (m_on && m_pos == 10 * D + 12) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reach_xfer got timeout want pos=%0d", 10 * D + 12);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (tif.ly !== 8'd0 || tif.mode !== HBLANK || tif.drawline !== 1'b0 ||
            tif.frame_done !== 1'b0 || tif.vblank_irq !== 1'b0 || tif.stat_irq !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got ly=%0d mode=%0d dl=%b fd=%b si=%b want all 0",
                     tif.ly, tif.mode, tif.drawline, tif.frame_done, tif.stat_irq);
        end
        reset_cycle();
        @(negedge clk); reset_cycle();
        @(negedge clk); rst = 1'b0;
        step(1'b1, 1'b1, 8'd0, 4'b1010);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); step(1'b1, 1'b1, 8'd0, 4'b1010);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
